// File: rtl/sprw_s2_reduce.sv
`default_nettype none
// ============================================================================
// Module  : sprw_s2_reduce
// Brief   : Two-stage masked lane reduction (SUM/MAX/MIN/XOR, signed and
//           unsigned, NOP pack) with valid/ready flow control.
//           Define SPRW_S2_ACC_EN to build the SUM/USUM accumulator.
// Revision: 1.0 - initial release
// ============================================================================
module sprw_s2_reduce #(
  parameter int LANES = 4,
  parameter int LW    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [LANES*LW-1:0] in_lanes,
  input  logic [2:0]          in_op2,
  input  logic [LANES-1:0]    in_mask,
`ifdef SPRW_S2_ACC_EN
  input  logic                in_acc,
`endif
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         out_result
);

  localparam int c_NP = LANES / 2;

  localparam logic [2:0] c_OP_NOP  = 3'b000;
  localparam logic [2:0] c_OP_SUM  = 3'b001;
  localparam logic [2:0] c_OP_MAX  = 3'b010;
  localparam logic [2:0] c_OP_MIN  = 3'b011;
  localparam logic [2:0] c_OP_XOR  = 3'b100;
  localparam logic [2:0] c_OP_USUM = 3'b101;
  localparam logic [2:0] c_OP_UMAX = 3'b110;
  localparam logic [2:0] c_OP_UMIN = 3'b111;

  function automatic logic f_signed(input logic [2:0] op);
    return (op == c_OP_SUM) || (op == c_OP_MAX) || (op == c_OP_MIN);
  endfunction

  // Lanes are widened to 32 bits up front so every combine works at one width;
  // sign-extended values order the same as the LW-bit signed compare.
  function automatic logic [31:0] f_ext(input logic [2:0] op,
                                        input logic [LW-1:0] lane,
                                        input logic en);
    logic [LW-1:0]      v;
    logic signed [31:0] s;
    v = lane;
    if (!en) begin
      case (op)
        c_OP_MAX:  v = {1'b1, {(LW-1){1'b0}}};
        c_OP_MIN:  v = {1'b0, {(LW-1){1'b1}}};
        c_OP_UMIN: v = '1;
        default:   v = '0;
      endcase
    end
    s = $signed(v);
    if (f_signed(op)) return s;
    return 32'(v);
  endfunction

  function automatic logic [31:0] f_comb(input logic [2:0] op,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
    case (op)
      c_OP_SUM, c_OP_USUM: return a + b;
      c_OP_MAX:  return ($signed(a) > $signed(b)) ? a : b;
      c_OP_MIN:  return ($signed(a) < $signed(b)) ? a : b;
      c_OP_UMAX: return (a > b) ? a : b;
      c_OP_UMIN: return (a < b) ? a : b;
      c_OP_XOR:  return a ^ b;
      default:   return a;
    endcase
  endfunction

  logic [c_NP-1:0][31:0] w_part;
  logic [c_NP-1:0][31:0] r_s1_part;
  logic                  r_s1_valid;
  logic [2:0]            r_s1_op;
  logic                  r_s2_valid;
  logic [31:0]           r_s2_result;
  logic                  w_s1_adv;
  logic                  w_s2_adv;
  logic [31:0]           w_red;
  logic [31:0]           w_total;

  assign w_s2_adv = !r_s2_valid || out_ready;
  assign w_s1_adv = !r_s1_valid || w_s2_adv;
  assign in_ready = w_s1_adv && !rst;

  // Mask is consumed here: masked lanes become identities inside each partial.
  genvar p;
  generate
    for (p = 0; p < c_NP; p++) begin : g_pair
      logic [LW-1:0] w_lo;
      logic [LW-1:0] w_hi;
      assign w_lo = in_lanes[2*p*LW +: LW];
      assign w_hi = in_lanes[(2*p+1)*LW +: LW];
      assign w_part[p] = (in_op2 == c_OP_NOP) ? {w_hi[15:0], w_lo[15:0]} :
                         f_comb(in_op2, f_ext(in_op2, w_lo, in_mask[2*p]),
                                        f_ext(in_op2, w_hi, in_mask[2*p+1]));
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_op    <= '0;
      r_s1_part  <= '0;
    end else if (w_s1_adv) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_op   <= in_op2;
        r_s1_part <= w_part;
      end
    end
  end

  always_comb begin
    w_red = r_s1_part[0];
    for (int i = 1; i < c_NP; i++) begin
      w_red = f_comb(r_s1_op, w_red, r_s1_part[i]);
    end
  end

`ifdef SPRW_S2_ACC_EN
  logic        r_s1_acc;
  logic [31:0] r_acc;
  logic        w_is_sum;

  assign w_is_sum = (r_s1_op == c_OP_SUM) || (r_s1_op == c_OP_USUM);
  assign w_total  = (w_is_sum && r_s1_acc) ? (w_red + r_acc) : w_red;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_acc <= 1'b0;
    end else if (w_s1_adv && in_valid) begin
      r_s1_acc <= in_acc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
    end else if (w_s2_adv && r_s1_valid && w_is_sum) begin
      r_acc <= w_total;
    end
  end
`else
  assign w_total = w_red;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid  <= 1'b0;
      r_s2_result <= '0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_result <= w_total;
      end
    end
  end

  assign out_valid  = r_s2_valid;
  assign out_result = r_s2_result;

endmodule
`default_nettype wire

// File: tb/tb_sprw_s2_reduce.sv
`default_nettype none
// ============================================================================
// Module  : tb_sprw_s2_reduce
// Brief   : Directed self-checking bench for sprw_s2_reduce.
// Revision: 1.0 - initial release
// ============================================================================
module tb_sprw_s2_reduce;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_SUM  = 3'b001;
  localparam logic [2:0] OP_MAX  = 3'b010;
  localparam logic [2:0] OP_MIN  = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_USUM = 3'b101;
  localparam logic [2:0] OP_UMAX = 3'b110;
  localparam logic [2:0] OP_UMIN = 3'b111;

  localparam logic [63:0] LANES_A = {16'h0004, 16'h0003, 16'hFFFF, 16'h0001};

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_lanes;
  logic [2:0]  in_op2;
  logic [3:0]  in_mask;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
`ifdef SPRW_S2_ACC_EN
  logic        in_acc;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sprw_s2_reduce #(.LANES(4), .LW(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_lanes   (in_lanes),
    .in_op2     (in_op2),
    .in_mask    (in_mask),
`ifdef SPRW_S2_ACC_EN
    .in_acc     (in_acc),
`endif
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result)
  );

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_lanes  = '0;
    in_op2    = OP_NOP;
    in_mask   = '0;
    out_ready = 1'b1;
`ifdef SPRW_S2_ACC_EN
    in_acc    = 1'b0;
`endif
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_result !== 32'h0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: valid=%b result=%h in_ready=%b, want 0/00000000/0",
               out_valid, out_result, in_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: in_ready=%b valid=%b, want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_ops();
    logic [2:0]  t_op  [16];
    logic [3:0]  t_msk [16];
    logic [31:0] t_exp [16];
    t_op  = '{OP_SUM, OP_USUM, OP_MAX, OP_UMAX, OP_MIN, OP_XOR, OP_UMIN, OP_MAX,
              OP_MIN, OP_UMIN, OP_NOP, OP_SUM, OP_SUM, OP_MIN, OP_UMAX, OP_MAX};
    t_msk = '{4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b0101, 4'b0000,
              4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1010, 4'b1101, 4'b0011, 4'b0010};
    t_exp = '{32'h00000007, 32'h00010007, 32'h00000004, 32'h0000FFFF,
              32'hFFFFFFFF, 32'h0000FFF9, 32'h00000001, 32'hFFFF8000,
              32'h00007FFF, 32'h0000FFFF, 32'hFFFF0001, 32'h00000000,
              32'h00000003, 32'h00000001, 32'h0000FFFF, 32'hFFFFFFFF};
    for (int k = 0; k < 16; k++) begin
      @(posedge clk); #1;
      in_valid  = 1'b1;
      in_op2    = t_op[k];
      in_lanes  = LANES_A;
      in_mask   = t_msk[k];
      out_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL ops[%0d] accept: in_ready=%b want 1", k, in_ready);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL ops[%0d] early: out_valid=%b want 0", k, out_valid);
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_result !== t_exp[k]) begin
        errors++;
        $display("FAIL ops[%0d] result: valid=%b result=%h, want 1/%h",
                 k, out_valid, out_result, t_exp[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      out_ready = 1'b1;
      if (c < 5) begin
        in_valid = 1'b1;
        in_op2   = OP_SUM;
        in_mask  = 4'b1111;
        in_lanes = {16'(c), 16'h0001, 16'hFFF0, 16'h0100};
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (c < 5) begin
        checks++;
        if (in_ready !== 1'b1) begin
          errors++;
          $display("FAIL b2b[%0d] in_ready=%b want 1", c, in_ready);
        end
      end
      checks++;
      if (c >= 2 && c <= 6) begin
        if (out_valid !== 1'b1 || out_result !== (32'h000000F1 + 32'(c - 2))) begin
          errors++;
          $display("FAIL b2b[%0d] result: valid=%b result=%h, want 1/%h",
                   c, out_valid, out_result, 32'h000000F1 + 32'(c - 2));
        end
      end else if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL b2b[%0d] idle: out_valid=%b want 0", c, out_valid);
      end
    end
  endtask

  task automatic test_backpressure();
    logic        t_iv  [8];
    logic [15:0] t_l0  [8];
    logic        t_or  [8];
    logic        t_rdy [8];
    logic        t_ov  [8];
    logic [31:0] t_res [8];
    t_iv  = '{1, 1, 1, 1, 1, 0, 0, 0};
    t_l0  = '{16'h11, 16'h22, 16'h33, 16'h33, 16'h33, 16'h0, 16'h0, 16'h0};
    t_or  = '{0, 0, 0, 0, 1, 1, 1, 1};
    t_rdy = '{1, 1, 0, 0, 1, 0, 0, 0};
    t_ov  = '{0, 0, 1, 1, 1, 1, 1, 0};
    t_res = '{32'h0, 32'h0, 32'h11, 32'h11, 32'h11, 32'h22, 32'h33, 32'h0};
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      in_valid  = t_iv[c];
      in_op2    = OP_SUM;
      in_mask   = 4'b1111;
      in_lanes  = {48'h0, t_l0[c]};
      out_ready = t_or[c];
      @(negedge clk);
      if (c < 5) begin
        checks++;
        if (in_ready !== t_rdy[c]) begin
          errors++;
          $display("FAIL bp[%0d] in_ready=%b want %b", c, in_ready, t_rdy[c]);
        end
      end
      checks++;
      if (out_valid !== t_ov[c] || (t_ov[c] && out_result !== t_res[c])) begin
        errors++;
        $display("FAIL bp[%0d] output: valid=%b result=%h, want %b/%h",
                 c, out_valid, out_result, t_ov[c], t_res[c]);
      end
    end
  endtask

  task automatic test_reset_flush();
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      out_ready = 1'b0;
      in_valid  = (c < 2);
      in_op2    = OP_SUM;
      in_mask   = 4'b1111;
      in_lanes  = {48'h0, (c == 0) ? 16'h44 : 16'h55};
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_full: valid=%b in_ready=%b, want 1/0", out_valid, in_ready);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_result !== 32'h0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_async: valid=%b result=%h in_ready=%b, want 0/00000000/0",
               out_valid, out_result, in_ready);
    end
    @(posedge clk); #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL flush_stale[%0d]: valid=%b in_ready=%b, want 0/1", c, out_valid, in_ready);
      end
    end
  endtask

`ifdef SPRW_S2_ACC_EN
  task automatic test_acc();
    logic [2:0]  t_op  [5];
    logic        t_acc [5];
    logic [31:0] t_exp [5];
    t_op  = '{OP_SUM, OP_SUM, OP_SUM, OP_XOR, OP_SUM};
    t_acc = '{0, 1, 1, 1, 1};
    t_exp = '{32'h4, 32'h8, 32'hC, 32'h0, 32'h10};
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      in_valid  = 1'b1;
      in_op2    = t_op[k];
      in_acc    = t_acc[k];
      in_lanes  = {4{16'h0001}};
      in_mask   = 4'b1111;
      out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_result !== t_exp[k]) begin
        errors++;
        $display("FAIL acc[%0d]: valid=%b result=%h, want 1/%h",
                 k, out_valid, out_result, t_exp[k]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_ops();
    test_back_to_back();
    test_backpressure();
    test_reset_flush();
`ifdef SPRW_S2_ACC_EN
    test_acc();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
